// File: rtl/wrr_grant_collector_if.sv
// Channel-source and output-stream signals of the WRR grant collector.
// The master side drives grants, channel words and out_ready; the slave side is the collector.
interface wrr_grant_collector_if #(
    parameter int CHANNELS = 8,
    parameter int DWIDTH   = 32,
    parameter int CWIDTH   = 3
);
    logic [CHANNELS-1:0]        grant;
    logic [CHANNELS-1:0]        ch_valid;
    logic [CHANNELS*DWIDTH-1:0] ch_data;
    logic [CHANNELS-1:0]        ch_pop;
    logic                       out_valid;
    logic                       out_ready;
    logic [DWIDTH-1:0]          out_data;
    logic [CWIDTH-1:0]          out_chan;

    modport master (
        output grant, ch_valid, ch_data, out_ready,
        input  ch_pop, out_valid, out_data, out_chan
    );

    modport slave (
        input  grant, ch_valid, ch_data, out_ready,
        output ch_pop, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/wrr_grant_collector.sv
// Takes the arbiter's one-hot grant, pops the granted channel's word and queues it with
// its channel tag in a show-ahead FIFO; flags multi-bit grants and counts wasted grants.
module wrr_grant_collector #(
    parameter int CHANNELS = 8,
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 8,
    parameter int CWIDTH   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    wrr_grant_collector_if.slave       bus,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_multi_grant,
    output logic [15:0]                wasted_grants
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              err_q, err_d;
    logic [15:0]       wasted_q, wasted_d;
    logic [DWIDTH-1:0] mem_data_q [DEPTH];
    logic [DWIDTH-1:0] mem_data_d [DEPTH];
    logic [CWIDTH-1:0] mem_chan_q [DEPTH];
    logic [CWIDTH-1:0] mem_chan_d [DEPTH];

    logic              onehot_s;
    logic              multi_s;
    logic              sel_valid_s;
    logic [CWIDTH-1:0] idx_s;
    logic [DWIDTH-1:0] sel_data_s;
    logic              accept_s;
    logic              pop_s;

    function automatic logic is_onehot(input logic [CHANNELS-1:0] v);
        return (v != '0) && ((v & (v - CHANNELS'(1))) == '0);
    endfunction

    // Grant decode: index, data and valid of the granted lane, plus accept/pop qualifiers.
    always_comb begin
        onehot_s    = is_onehot(bus.grant);
        multi_s     = (bus.grant != '0) && !onehot_s;
        idx_s       = '0;
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx_s       = bus.grant[i] ? CWIDTH'(i) : idx_s;
            sel_valid_s = bus.grant[i] ? bus.ch_valid[i] : sel_valid_s;
            sel_data_s  = bus.grant[i] ? bus.ch_data[i*DWIDTH +: DWIDTH] : sel_data_s;
        end
        // Full is judged on the current count alone, so a same-cycle pop cannot make room.
        accept_s = !reset && onehot_s && sel_valid_s && (count_q < FULL_COUNT);
        pop_s    = (count_q != '0) && bus.out_ready;
    end

    // Next-state for pointers, occupancy, storage and the error/waste counters.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_data_d = mem_data_q;
        mem_chan_d = mem_chan_q;
        if (accept_s) begin
            mem_data_d[wr_ptr_q] = sel_data_s;
            mem_chan_d[wr_ptr_q] = idx_s;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q | multi_s;
        if (onehot_s && !sel_valid_s && (wasted_q != 16'hFFFF)) begin
            wasted_d = wasted_q + 16'd1;
        end else begin
            wasted_d = wasted_q;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            wasted_q <= 16'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            wasted_q <= wasted_d;
        end
    end

    // FIFO storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_chan_q <= mem_chan_d;
    end

    assign bus.ch_pop      = accept_s ? bus.grant : '0;
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_data    = mem_data_q[rd_ptr_q];
    assign bus.out_chan    = mem_chan_q[rd_ptr_q];
    assign fifo_count      = count_q;
    assign err_multi_grant = err_q;
    assign wasted_grants   = wasted_q;
endmodule

// File: tb/tb_wrr_grant_collector.sv
// Bench for wrr_grant_collector: directed vector table, saturation run and random traffic,
// all checked against a queue-based model of the collector.
module tb_wrr_grant_collector;
    localparam int CH = 8, DW = 32, DEPTH = 8, CW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_count;
    logic        err_multi_grant;
    logic [15:0] wasted_grants;

    always #5 clk = ~clk;

    wrr_grant_collector_if #(.CHANNELS(CH), .DWIDTH(DW), .CWIDTH(CW)) bus ();

    wrr_grant_collector #(.CHANNELS(CH), .DWIDTH(DW), .DEPTH(DEPTH), .CWIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .fifo_count      (fifo_count),
        .err_multi_grant (err_multi_grant),
        .wasted_grants   (wasted_grants)
    );

    typedef struct packed { logic [2:0] ch; logic [31:0] d; } ent_t;
    typedef struct {
        bit rst; logic [7:0] g; logic [7:0] v; bit rdy;
        logic [7:0] pop; bit vld; logic [2:0] chan; logic [3:0] cnt; bit err; logic [15:0] wst;
    } vec_t;

    ent_t mq[$];
    bit   m_err;
    int   m_wasted;
    bit   model_ok = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, logic [7:0] g, logic [7:0] v, bit rdy, logic [7:0] pop,
                                bit vld, logic [2:0] chan, logic [3:0] cnt, bit err, logic [15:0] wst);
        vec_t t;
        t.rst = rst; t.g = g; t.v = v; t.rdy = rdy; t.pop = pop;
        t.vld = vld; t.chan = chan; t.cnt = cnt; t.err = err; t.wst = wst;
        return t;
    endfunction

    function automatic int grant_index(logic [7:0] g);
        int idx = 0;
        for (int i = 0; i < CH; i++) if (g[i]) idx = i;
        return idx;
    endfunction

    function automatic bit model_accept();
        return !reset && ($countones(bus.grant) == 1) && bus.ch_valid[grant_index(bus.grant)]
               && (mq.size() < DEPTH);
    endfunction

    task automatic drive(input bit rst, input logic [7:0] g, input logic [7:0] v, input bit rdy);
        reset = rst; bus.grant = g; bus.ch_valid = v; bus.out_ready = rdy;
        #1;
    endtask

    task automatic model_check(input string tag);
        if (model_ok) begin
            chk({tag, "_ch_pop"}, bus.ch_pop, model_accept() ? bus.grant : 8'h00);
            chk({tag, "_out_valid"}, bus.out_valid, mq.size() != 0);
            chk({tag, "_fifo_count"}, fifo_count, mq.size());
            chk({tag, "_err"}, err_multi_grant, m_err);
            chk({tag, "_wasted"}, wasted_grants, m_wasted);
            if (mq.size() != 0) begin
                chk({tag, "_out_chan"}, bus.out_chan, mq[0].ch);
                chk({tag, "_out_data"}, bus.out_data, mq[0].d);
            end
        end
    endtask

    task automatic tick();
        int   n, idx;
        bit   acc, pp;
        ent_t e;
        n   = $countones(bus.grant);
        idx = grant_index(bus.grant);
        acc = model_accept();
        pp  = !reset && (mq.size() != 0) && bus.out_ready;
        e.ch = 3'(idx);
        e.d  = bus.ch_data[idx*DW +: DW];
        @(posedge clk);
        if (reset) begin
            mq.delete(); m_err = 1'b0; m_wasted = 0; model_ok = 1'b1;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (n >= 2) m_err = 1'b1;
            if (n == 1 && !bus.ch_valid[idx] && m_wasted < 65535) m_wasted++;
        end
        #1;
    endtask

    initial begin
        // Directed vectors: expected values are the state seen before each edge.
        tbl.push_back(mk(0, 8'h04, 8'hFF, 1, 8'h04, 0, 3'd0, 4'd0, 0, 16'd0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 1, 3'd2, 4'd1, 0, 16'd0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd0, 0, 16'd0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 8'(1) << k, 8'hFF, 0, 8'(1) << k, k > 0, 3'd0, 4'(k), 0, 16'd0));
        tbl.push_back(mk(0, 8'h01, 8'hFF, 0, 8'h00, 1, 3'd0, 4'd8, 0, 16'd0));
        tbl.push_back(mk(0, 8'h01, 8'hFF, 1, 8'h00, 1, 3'd0, 4'd8, 0, 16'd0));
        tbl.push_back(mk(0, 8'h01, 8'hFF, 1, 8'h01, 1, 3'd1, 4'd7, 0, 16'd0));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 1, 3'((k + 2) % 8), 4'(7 - k), 0, 16'd0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd0, 0, 16'd0));
        tbl.push_back(mk(0, 8'h03, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd0, 0, 16'd0));
        tbl.push_back(mk(0, 8'h04, 8'hFF, 1, 8'h04, 0, 3'd0, 4'd0, 1, 16'd0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 1, 3'd2, 4'd1, 1, 16'd0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd0, 1, 16'd0));
        tbl.push_back(mk(1, 8'h00, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd0, 1, 16'd0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd0, 0, 16'd0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 8'(1) << k, 8'hFF, 0, 8'(1) << k, k > 0, 3'd0, 4'(k), 0, 16'd0));
        tbl.push_back(mk(1, 8'h02, 8'hFF, 0, 8'h00, 1, 3'd0, 4'd5, 0, 16'd0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 8'h00, 0, 3'd0, 4'd0, 0, 16'd0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 8'h10, 8'hEF, 1, 8'h00, 0, 3'd0, 4'd0, 0, 16'(k)));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd3, 0, 16'd3));
        tbl[tbl.size()-1].cnt = 4'd0;

        for (int i = 0; i < CH; i++) bus.ch_data[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);

        // Two reset cycles; ch_pop must stay low even with a valid grant present.
        drive(1, 8'h04, 8'hFF, 1);
        chk("reset_ch_pop", bus.ch_pop, 8'h00);
        tick();
        drive(1, 8'h04, 8'hFF, 1);
        chk("reset_ch_pop2", bus.ch_pop, 8'h00);
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].g, tbl[i].v, tbl[i].rdy);
            chk($sformatf("v%0d_ch_pop", i), bus.ch_pop, tbl[i].pop);
            chk($sformatf("v%0d_out_valid", i), bus.out_valid, tbl[i].vld);
            chk($sformatf("v%0d_fifo_count", i), fifo_count, tbl[i].cnt);
            chk($sformatf("v%0d_err", i), err_multi_grant, tbl[i].err);
            chk($sformatf("v%0d_wasted", i), wasted_grants, tbl[i].wst);
            if (tbl[i].vld) begin
                chk($sformatf("v%0d_out_chan", i), bus.out_chan, tbl[i].chan);
                chk($sformatf("v%0d_out_data", i), bus.out_data, 32'hA5A5_0000 | 32'(tbl[i].chan));
            end
            model_check($sformatf("m%0d", i));
            tick();
        end

        // Saturation of the wasted-grant counter.
        for (int i = 0; i < 65540; i++) begin
            drive(0, 8'h10, 8'hEF, 1);
            tick();
        end
        drive(0, 8'h00, 8'hFF, 1);
        chk("wasted_saturated", wasted_grants, 16'hFFFF);
        model_check("sat");
        tick();

        // Random traffic including rare resets, zero grants and multi-bit grants.
        for (int c = 0; c < 600; c++) begin
            int          r;
            logic [7:0]  g;
            r = $urandom_range(0, 9);
            if (r == 0)      g = 8'h00;
            else if (r == 1) g = 8'($urandom());
            else             g = 8'(1) << $urandom_range(0, 7);
            for (int i = 0; i < CH; i++) bus.ch_data[i*DW +: DW] = $urandom();
            drive($urandom_range(0, 99) == 0, g, 8'($urandom() | $urandom()),
                  $urandom_range(0, 3) != 0);
            model_check($sformatf("r%0d", c));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wrr_grant_collector.md
Name: wrr_grant_collector

Overview:
- Downstream stage of the weighted round-robin arbiter. Consumes the arbiter's one-hot grant vector each cycle.
- Pops one word from the granted channel's source and tags it with the channel index.
- Buffers tagged words in an output FIFO and presents them on a valid/ready output port.
- Flags illegal grant vectors and counts wasted grants, where the granted channel has no data.

Parameters:
- CHANNELS, 8, number of request channels; must match arbiter CHANNELS.
- DWIDTH, 32, data word width per channel.
- DEPTH, 8, output FIFO entries; power of 2, ≥2.
- CWIDTH, 3, channel index width; equals clog2(CHANNELS).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- grant  input  CHANNELS  one-hot grant from arbiter; all-zero means no grant.
- ch_valid  input  CHANNELS  per-channel "word available" flags.
- ch_data  input  CHANNELS*DWIDTH  per-channel words; channel i occupies bits [i*DWIDTH +: DWIDTH].
- ch_pop  output  CHANNELS  one-hot combinational acknowledge; source i dequeues on the clk edge where ch_pop[i]=1.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  DWIDTH  head data word.
- out_chan  output  CWIDTH  head channel index.
- fifo_count  output  clog2(DEPTH)+1  current occupancy.
- err_multi_grant  output  1  sticky; set when grant had more than one bit set.
- wasted_grants  output  16  saturating count of grants to channels with ch_valid=0.

Behaviour:
- Reset, synchronous, clk edge with reset=1:
  - FIFO pointers and count go to 0, so out_valid=0 and fifo_count=0.
  - err_multi_grant=0, wasted_grants=0.
  - ch_pop=0 while reset is high.
  - Reset mid-stream discards all buffered entries. No pop is issued in that cycle.
- Grant decode, combinational:
  - onehot = grant!=0 and (grant & (grant-1))==0.
  - idx = position of the set bit.
- Accept condition:
  - accept = !reset & onehot & ch_valid[idx] & (fifo_count < DEPTH).
  - Full is evaluated on the current count only. A push is refused when fifo_count==DEPTH, even if a pop occurs in the same cycle.
  - ch_pop = accept ? grant : 0.
- Push: on an accept edge, write {idx, ch_data[idx]} at the write pointer and advance it modulo DEPTH.
- Pop: on an edge with out_valid & out_ready, advance the read pointer modulo DEPTH.
- Count update:
  - fifo_count += accept - pop.
  - Simultaneous push and pop leaves the count unchanged and both pointers advance.
- Output timing:
  - Show-ahead FIFO: out_valid = (fifo_count != 0). out_data and out_chan reflect the head entry combinationally from storage.
  - A word accepted into an empty FIFO appears on out_valid the next cycle, so latency is 1 cycle.
  - While out_valid=1 and out_ready=0, out_data and out_chan hold stable.
- Multi-grant:
  - If grant has ≥2 bits set: no accept, ch_pop=0, and err_multi_grant sets at that edge.
  - err_multi_grant stays set until reset.
- Zero grant: no action and no error.
- Wasted grant:
  - If onehot & !ch_valid[idx], wasted_grants increments at the edge, saturating at 16'hFFFF.
  - A grant refused only because the FIFO is full is not counted as wasted.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally. The count, not pointer equality, distinguishes full from empty.
- out_valid/out_ready behaviour is independent of grant activity. Full throughput is 1 word/cycle in and out simultaneously.

Test Plan:
1. Reset → all-zero outputs; push 1:
   - Reset 2 cycles, then grant=8'h04, ch_valid=8'hFF, ch_data lane2=32'hA5A5_0002, out_ready=1.
   - ch_pop=8'h04 that cycle. Next cycle out_valid=1, out_data=32'hA5A5_0002, out_chan=2. Following cycle out_valid=0.
2. Fill to full:
   - out_ready=0, grants cycle through channels 0..7 with valid data; then grant channel 0 again.
   - fifo_count reaches 8. The 9th grant gives ch_pop=0 and wasted_grants is unchanged.
   - Drain with out_ready=1: out_chan sequence 0..7 in order, with matching data.
3. Simultaneous push/pop at full:
   - count=8, grant=8'h01, out_ready=1.
   - Push refused (ch_pop=0) and count goes to 7. Next cycle the push is accepted while popping, and count stays 7.
4. Wasted grant:
   - grant=8'h10, ch_valid=8'hEF for 3 cycles → wasted_grants=3, no push.
   - Preload wasted_grants to 16'hFFFF via 65535 wasted cycles (or a long run) → it stays at 16'hFFFF.
5. Multi-grant:
   - grant=8'h03 → ch_pop=0, no push, err_multi_grant=1 next cycle.
   - Later valid grants push normally. err_multi_grant stays 1 until reset, then reads 0.
6. Reset mid-operation:
   - count=5, out_valid=1, assert reset for 1 cycle with grant=8'h02.
   - ch_pop=0 and the next cycle fifo_count=0, out_valid=0. Pointer wrap is then verified by pushing/popping 20 words with matching data.
